// File: rtl/motor_throttle_sequencer.sv
// Arm/disarm sequencing, per-motor throttle targets and frame-aligned duty updates for four PWM
// channels. Define SLEW_LIMIT_EN to rate-limit duty changes at each ARMED frame boundary.
module motor_throttle_sequencer #(
  parameter int unsigned ARM_PERIODS     = 64,
  parameter int unsigned TIMEOUT_PERIODS = 512,
  parameter logic [7:0]  IDLE_DUTY       = 8'd10,
  parameter int unsigned RAMP_STEP       = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        arm_in,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic [1:0]  cmd_motor_in,
  input  logic [7:0]  cmd_value_in,
  output logic [31:0] duty_out,
  output logic        frame_tick_out,
  output logic [1:0]  state_out
);

  localparam logic [1:0] StDisarmed = 2'd0;
  localparam logic [1:0] StArming   = 2'd1;
  localparam logic [1:0] StArmed    = 2'd2;
  localparam logic [1:0] StFailsafe = 2'd3;

  localparam int unsigned WdW  = $clog2(TIMEOUT_PERIODS + 1);
  localparam int unsigned ArmW = $clog2(ARM_PERIODS + 1);
  localparam logic [WdW-1:0]  TimeoutLim = WdW'(TIMEOUT_PERIODS);
  localparam logic [ArmW-1:0] ArmLim     = ArmW'(ARM_PERIODS);

  // A zero period or step would stall the sequencer, so refuse it at elaboration.
  if (ARM_PERIODS == 0 || TIMEOUT_PERIODS == 0 || RAMP_STEP == 0) begin : gen_param_check
    $error("motor_throttle_sequencer: ARM_PERIODS, TIMEOUT_PERIODS, RAMP_STEP must be nonzero");
  end

`ifdef SLEW_LIMIT_EN
  localparam logic [7:0] RampStep = (RAMP_STEP > 255) ? 8'd255 : 8'(RAMP_STEP);

  function automatic logic [7:0] slew_step(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] up;
    up = {1'b0, cur} + {1'b0, RampStep};
    if (tgt > cur) begin
      slew_step = (up > {1'b0, tgt}) ? tgt : up[7:0];
    end else if (cur - tgt > RampStep) begin
      slew_step = cur - RampStep;
    end else begin
      slew_step = tgt;
    end
  endfunction
`endif

  logic [1:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [3:0][7:0]       duty_q, duty_d;
  logic [3:0][7:0]       target_q, target_d;
  logic [WdW-1:0]        wdog_q, wdog_d, wdog_inc;
  logic [ArmW-1:0]       armc_q, armc_d, armc_inc;
  logic                  ready_q, ready_d;
  logic                  boundary;
  logic                  accept;
  logic [7:0]            cmd_clamped;

  assign boundary    = (cnt_q == 8'hff);
  assign accept      = cmd_valid_in & ready_q;
  assign cmd_clamped = (cmd_value_in < IDLE_DUTY) ? IDLE_DUTY : cmd_value_in;
  assign wdog_inc    = wdog_q + WdW'(1);
  assign armc_inc    = armc_q + ArmW'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 8'd1;
    duty_d   = duty_q;
    target_d = target_q;
    wdog_d   = wdog_q;
    armc_d   = armc_q;

    case (state_q)
      StDisarmed: begin
        duty_d = '0;
        if (arm_in) begin
          state_d  = StArming;
          armc_d   = '0;
          target_d = {4{IDLE_DUTY}};
        end
      end

      StArming: begin
        if (!arm_in) begin
          state_d  = StDisarmed;
          duty_d   = '0;
          target_d = '0;
        end else if (boundary) begin
          duty_d = {4{IDLE_DUTY}};
          armc_d = armc_inc;
          if (armc_inc == ArmLim) begin
            state_d = StArmed;
            wdog_d  = '0;
          end
        end
      end

      StArmed: begin
        if (!arm_in) begin
          state_d  = StDisarmed;
          duty_d   = '0;
          target_d = '0;
        end else begin
          if (accept) begin
            target_d[cmd_motor_in] = cmd_clamped;
            wdog_d                 = '0;
          end
          // The boundary applies the pre-edge targets; a kick on this edge still resets the dog.
          if (boundary) begin
            if (!accept && wdog_inc == TimeoutLim) begin
              state_d = StFailsafe;
              duty_d  = '0;
            end else begin
              if (!accept) begin
                wdog_d = wdog_inc;
              end
              for (int n = 0; n < 4; n++) begin
`ifdef SLEW_LIMIT_EN
                duty_d[n] = slew_step(duty_q[n], target_q[n]);
`else
                duty_d[n] = target_q[n];
`endif
              end
            end
          end
        end
      end

      default: begin
        duty_d = '0;
        if (!arm_in) begin
          state_d  = StDisarmed;
          target_d = '0;
        end
      end
    endcase

    ready_d = (state_d == StArmed);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= StDisarmed;
      cnt_q    <= '0;
      duty_q   <= '0;
      target_q <= '0;
      wdog_q   <= '0;
      armc_q   <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      wdog_q   <= wdog_d;
      armc_q   <= armc_d;
      ready_q  <= ready_d;
    end
  end

  assign cmd_ready_out  = ready_q;
  assign duty_out       = duty_q;
  assign frame_tick_out = boundary;
  assign state_out      = state_q;

endmodule
